// File: rtl/nibble_ser_tx_pkg.sv
// nibble_ser_tx_pkg
// Shared definitions for the nibble serial transmitter: state encoding,
// frame lengths and the cycle-counter width.

package nibble_ser_tx_pkg;

    // Transmitter states. PARITY only ever becomes reachable when the
    // parity option is compiled into the top level.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Frame length in bit periods: start + 4 data + stop, plus parity.
    localparam int FRAME_BITS_NOPAR = 6;
    localparam int FRAME_BITS_PAR   = 7;

    // Cycle counter width; wide enough for DIV up to 255.
    localparam int CNT_W = 8;

    // Largest legal bit period in clock cycles.
    localparam int DIV_MAX = 255;

    // Even parity over one nibble: 1 when the nibble has an odd number of ones.
    function automatic logic even_parity(input logic [3:0] nib);
        return ^nib;
    endfunction

endpackage

// File: rtl/nibble_ser_tx_bit_tick.sv
// nibble_ser_tx_bit_tick
// Bit-period timer. Counts clock cycles while enabled and raises tick on the
// last cycle of every bit period, wrapping the count back to 0 on that same
// edge. With DIV=1 the count stays at 0 and tick is high on every enabled
// cycle. Cleared by reset and by the handshake accept edge so every frame
// starts its first bit with a fresh count.

module nibble_ser_tx_bit_tick
    import nibble_ser_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Elaboration-time range guard on the bit period.
    if ((DIV < 1) || (DIV > DIV_MAX)) begin : g_bad_div
        $error("nibble_ser_tx_bit_tick: DIV must be in 1..255");
    end

    assign tick = en && (cnt_q == LAST_CNT);

    // Next count: restart on clear, when idle, or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || !en || tick) begin
            cnt_d = '0;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_ser_tx.sv
// nibble_ser_tx
// Serial transmitter for 4-bit words. A nibble accepted on valid & ready is
// sent as start bit, 4 data bits LSB first, optional even-parity bit and a
// stop bit, each bit lasting DIV clock cycles. txd, busy and done are
// registered, so valid/din never reach txd combinationally.
// Optional feature: define TX_PARITY_EN to compile in the PARITY state.

module nibble_ser_tx
    import nibble_ser_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] shift_q;
    logic [3:0] shift_d;
    logic [1:0] bit_cnt_q;
    logic [1:0] bit_cnt_d;
    logic       txd_q;
    logic       txd_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;
`ifdef TX_PARITY_EN
    logic       parity_q;
    logic       parity_d;
`endif

    logic       accept;
    logic       running;
    logic       tick;

    // ready is decoded straight from the state register, so it is high in
    // the done cycle and back-to-back frames need no idle gap.
    assign ready   = (state_q == ST_IDLE);
    assign accept  = valid && ready;
    assign running = (state_q != ST_IDLE);

    nibble_ser_tx_bit_tick #(
        .DIV (DIV)
    ) u_bit_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (running),
        .tick (tick)
    );

    // Next-state and next-output logic. txd_d is the line level for the
    // state being entered, so the registered txd lines up with the state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = din;
                    bit_cnt_d = 2'd0;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
`ifdef TX_PARITY_EN
                    parity_d  = even_parity(din);
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // Shift after every bit; bit_cnt wraps 3 -> 0 on exit.
                    shift_d   = {1'b0, shift_q[3:1]};
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= 4'd0;
            bit_cnt_q <= 2'd0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef TX_PARITY_EN
    // Parity of the captured nibble, held for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_nibble_ser_tx.sv
// tb_nibble_ser_tx
// Three transmitters (DIV = 4, 2, 1) share clock and reset. The stimulus
// pushes the hand-computed line pattern of every frame it expects into a
// per-instance queue; a monitor per instance pops a pattern whenever a start
// bit appears and checks every cycle of the frame plus the done cycle.

module tb_nibble_ser_tx;
    import nibble_ser_tx_pkg::*;

    localparam int NDUT = 3;

`ifdef TX_PARITY_EN
    localparam int NB = FRAME_BITS_PAR;
    // Line patterns, bit i = txd during bit period i (start first).
    localparam logic [6:0] EXP_A = 7'h54;  // 0,0,1,0,1,p0,1
    localparam logic [6:0] EXP_3 = 7'h46;  // 0,1,1,0,0,p0,1
    localparam logic [6:0] EXP_C = 7'h58;  // 0,0,0,1,1,p0,1
    localparam logic [6:0] EXP_5 = 7'h4A;  // 0,1,0,1,0,p0,1
    localparam logic [6:0] EXP_7 = 7'h6E;  // 0,1,1,1,0,p1,1
`else
    localparam int NB = FRAME_BITS_NOPAR;
    localparam logic [6:0] EXP_A = 7'h34;  // 0,0,1,0,1,1
    localparam logic [6:0] EXP_3 = 7'h26;  // 0,1,1,0,0,1
    localparam logic [6:0] EXP_C = 7'h38;  // 0,0,0,1,1,1
    localparam logic [6:0] EXP_5 = 7'h2A;  // 0,1,0,1,0,1
    localparam logic [6:0] EXP_7 = 7'h2E;  // 0,1,1,1,0,1
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NDUT-1:0] valid;
    logic [NDUT-1:0] ready;
    logic [NDUT-1:0] txd;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;
    logic [3:0]      din [NDUT];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [6:0] q0[$];
    logic [6:0] q1[$];
    logic [6:0] q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int i, input logic [6:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsz(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [6:0] pop_exp(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 4 : ((gi == 1) ? 2 : 1);

        nibble_ser_tx #(
            .DIV (D)
        ) u_dut (
            .clk   (clk),
            .rst   (rst_n),
            .din   (din[gi]),
            .valid (valid[gi]),
            .ready (ready[gi]),
            .txd   (txd[gi]),
            .busy  (busy[gi]),
            .done  (done[gi])
        );

        // Monitor: idle checks each cycle, full frame check on a start bit.
        initial begin : mon
            logic [6:0] e;
            bit         aborted;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) continue;
                if (txd[gi] === 1'b0) begin
                    check($sformatf("dut%0d_frame_expected", gi), (qsz(gi) != 0), 1);
                    e = (qsz(gi) != 0) ? pop_exp(gi) : 7'h7F;
                    aborted = 1'b0;
                    for (int c = 0; c < NB * D; c++) begin
                        if (c != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        check($sformatf("dut%0d_txd_c%0d", gi, c), txd[gi], e[c / D]);
                        check($sformatf("dut%0d_busy_c%0d", gi, c), busy[gi], 1);
                        check($sformatf("dut%0d_ready_c%0d", gi, c), ready[gi], 0);
                        check($sformatf("dut%0d_done_c%0d", gi, c), done[gi], 0);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (rst_n === 1'b1) begin
                            check($sformatf("dut%0d_done_pulse", gi), done[gi], 1);
                            check($sformatf("dut%0d_done_ready", gi), ready[gi], 1);
                            check($sformatf("dut%0d_done_busy", gi), busy[gi], 0);
                            check($sformatf("dut%0d_done_txd", gi), txd[gi], 1);
                        end
                    end
                end else begin
                    check($sformatf("dut%0d_idle_busy", gi), busy[gi], 0);
                    check($sformatf("dut%0d_idle_ready", gi), ready[gi], 1);
                    check($sformatf("dut%0d_idle_done", gi), done[gi], 0);
                end
            end
        end
    end

    // Offer a nibble and hold valid until the accept edge; t = cycle of that edge.
    task automatic send(input int i, input logic [3:0] d, input logic [6:0] e, output int t);
        bit ok;
        ok = 1'b0;
        din[i]   = d;
        valid[i] = 1'b1;
        push_exp(i, e);
        for (int k = 0; k < 300 && !ok; k++) begin
            if (ready[i] === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        t = cyc;
        check($sformatf("dut%0d_accept", i), ok, 1);
    endtask

    task automatic wait_done(input int i, output int t);
        bit seen;
        seen = 1'b0;
        t = -1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done[i] === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        check($sformatf("dut%0d_done_seen", i), seen, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        int t1;
        valid = '0;
        for (int i = 0; i < NDUT; i++) din[i] = 4'd0;
        rst_n = 1'b0;

        // Reset state with the clock running.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_txd%0d", i), txd[i], 1);
            check($sformatf("rst_ready%0d", i), ready[i], 1);
            check($sformatf("rst_busy%0d", i), busy[i], 0);
            check($sformatf("rst_done%0d", i), done[i], 0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // DIV=4, 4'b1010; a 4'hF pulse mid-frame must be ignored.
        send(0, 4'hA, EXP_A, t0);
        valid[0] = 1'b0;
        repeat (10) @(negedge clk);
        din[0]   = 4'hF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_done(0, t1);
        check("div4_frame_len", t1 - t0, NB * 4);
        repeat (40) @(negedge clk);

        // DIV=2 back-to-back with valid held high: 26 cycles from the first
        // START cycle through the second done cycle inclusive.
        send(1, 4'h3, EXP_3, t0);
        send(1, 4'hC, EXP_C, t1);
        valid[1] = 1'b0;
        check("b2b_second_accept", t1 - t0, NB * 2 + 1);
        wait_done(1, t1);
        check("b2b_total", t1 - t0 + 1, 2 * (NB * 2 + 1));
        repeat (20) @(negedge clk);

        // Abort in data bit 2 on DIV=4, then a clean frame.
        send(0, 4'hA, EXP_A, t0);
        valid[0] = 1'b0;
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_txd", txd[0], 1);
        check("abort_busy", busy[0], 0);
        check("abort_ready", ready[0], 1);
        check("abort_done", done[0], 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 4'h5, EXP_5, t0);
        valid[0] = 1'b0;
        wait_done(0, t1);
        check("abort_new_frame_len", t1 - t0, NB * 4);
        repeat (10) @(negedge clk);

        // DIV=1, 4'b0111.
        send(2, 4'h7, EXP_7, t0);
        valid[2] = 1'b0;
        wait_done(2, t1);
        check("div1_frame_len", t1 - t0, NB);
        repeat (20) @(negedge clk);

        check("q0_drained", qsz(0), 0);
        check("q1_drained", qsz(1), 0);
        check("q2_drained", qsz(2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
